// File: rtl/intersect_seq.sv
// rtl/intersect_seq.sv - ray-sphere discriminant sequencer sharing one dot_product unit
// Runs a, b, c through the external unit in DA/DB/DC, then forms d = b*b - 4ac.
module intersect_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [191:0] in_origin,
  input  logic [191:0] in_dir,
  input  logic [191:0] in_center,
  input  logic [63:0]  in_rad,
  output logic [191:0] dp_i,
  output logic [191:0] dp_n,
  input  logic [63:0]  dp_dot,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_hit,
  output logic [63:0]  out_disc,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_OC, S_DA, S_DB, S_DC, S_DISC, S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [191:0] origin_q, origin_d;
  logic [191:0] dir_q, dir_d;
  logic [191:0] center_q, center_d;
  logic [63:0]  rad_q, rad_d;
  logic [191:0] oc_q, oc_d;
  logic [63:0]  a_q, a_d;
  logic [63:0]  b_q, b_d;
  logic [63:0]  c_q, c_d;
  logic [63:0]  disc_q, disc_d;
  logic         hit_q, hit_d;

  function automatic logic [63:0] f_sub(input logic [63:0] x, input logic [63:0] y);
    return $realtobits($bitstoreal(x) - $bitstoreal(y));
  endfunction

  function automatic logic [63:0] f_mul(input logic [63:0] x, input logic [63:0] y);
    return $realtobits($bitstoreal(x) * $bitstoreal(y));
  endfunction

  function automatic logic [191:0] v_sub(input logic [191:0] x, input logic [191:0] y);
    return {f_sub(x[191:128], y[191:128]), f_sub(x[127:64], y[127:64]), f_sub(x[63:0], y[63:0])};
  endfunction

  function automatic logic [63:0] f_disc(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] c);
    return $realtobits($bitstoreal(b) * $bitstoreal(b)
                       - 4.0 * $bitstoreal(a) * $bitstoreal(c));
  endfunction

  // Strict compare: NaN, +0.0 and -0.0 all report a miss.
  function automatic logic f_pos(input logic [63:0] x);
    return $bitstoreal(x) > 0.0;
  endfunction

  always_comb begin
    state_d  = state_q;
    origin_d = origin_q;
    dir_d    = dir_q;
    center_d = center_q;
    rad_d    = rad_q;
    oc_d     = oc_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    disc_d   = disc_q;
    hit_d    = hit_q;
    dp_i     = '0;
    dp_n     = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          origin_d = in_origin;
          dir_d    = in_dir;
          center_d = in_center;
          rad_d    = in_rad;
          state_d  = S_OC;
        end
      end
      S_OC: begin
        oc_d    = v_sub(origin_q, center_q);
        state_d = S_DA;
      end
      S_DA: begin
        dp_i    = dir_q;
        dp_n    = dir_q;
        a_d     = dp_dot;
        state_d = S_DB;
      end
      S_DB: begin
        dp_i    = oc_q;
        dp_n    = dir_q;
        b_d     = f_mul(64'h4000_0000_0000_0000, dp_dot);
        state_d = S_DC;
      end
      S_DC: begin
        dp_i    = oc_q;
        dp_n    = oc_q;
        c_d     = f_sub(dp_dot, f_mul(rad_q, rad_q));
        state_d = S_DISC;
      end
      S_DISC: begin
        disc_d  = f_disc(a_q, b_q, c_q);
        hit_d   = f_pos(disc_d);
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      origin_q <= '0;
      dir_q    <= '0;
      center_q <= '0;
      rad_q    <= '0;
      oc_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      disc_q   <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      origin_q <= origin_d;
      dir_q    <= dir_d;
      center_q <= center_d;
      rad_q    <= rad_d;
      oc_q     <= oc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      disc_q   <= disc_d;
      hit_q    <= hit_d;
    end
  end

  assign out_hit  = hit_q;
  assign out_disc = disc_q;

endmodule

// File: tb/tb_intersect_seq.sv
// tb/tb_intersect_seq.sv - directed scoreboard bench for intersect_seq
// Drives jobs through a behavioural dot_product and compares results against expected constants.
module tb_intersect_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [191:0] in_origin, in_dir, in_center;
  logic [63:0]  in_rad;
  logic [191:0] dp_i, dp_n;
  logic [63:0]  dp_dot;
  logic         out_valid;
  logic         out_ready;
  logic         out_hit;
  logic [63:0]  out_disc;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] disc;
    logic        hit;
    bit          is_nan;
  } exp_t;
  exp_t sb[$];

  logic [191:0] cur_dir, cur_oc;

  always #5 clk = ~clk;

  intersect_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_origin(in_origin), .in_dir(in_dir), .in_center(in_center), .in_rad(in_rad),
    .dp_i(dp_i), .dp_n(dp_n), .dp_dot(dp_dot),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_disc(out_disc), .busy(busy)
  );

  function automatic real comp(input logic [191:0] v, input int k);
    return $bitstoreal(v[k*64 +: 64]);
  endfunction

  function automatic logic [191:0] vec(input real x, input real y, input real z);
    return {$realtobits(x), $realtobits(y), $realtobits(z)};
  endfunction

  always_comb begin
    dp_dot = $realtobits(comp(dp_i, 2) * comp(dp_n, 2) + comp(dp_i, 1) * comp(dp_n, 1)
                         + comp(dp_i, 0) * comp(dp_n, 0));
  end

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_dp_i"}, dp_i, 0);
    check({tag, "_dp_n"}, dp_n, 0);
  endtask

  task automatic accept_job(input logic [191:0] o, input logic [191:0] d, input logic [191:0] c,
                            input logic [63:0] r, input real e_disc, input logic e_hit,
                            input bit e_nan);
    exp_t e;
    in_origin = o;
    in_dir    = d;
    in_center = c;
    in_rad    = r;
    in_valid  = 1'b1;
    cur_dir   = d;
    cur_oc    = vec(comp(o, 2) - comp(c, 2), comp(o, 1) - comp(c, 1), comp(o, 0) - comp(c, 0));
    check("accept_in_ready", in_ready, 1);
    e.disc = $realtobits(e_disc);
    e.hit = e_hit;
    e.is_nan = e_nan;
    sb.push_back(e);
    step();
    in_valid = 1'b0;
    check("post_accept_busy", busy, 1);
    check("post_accept_in_ready", in_ready, 0);
  endtask

  task automatic check_ops(input int k);
    logic [191:0] ei, en;
    ei = '0;
    en = '0;
    if (k == 1) begin ei = cur_dir; en = cur_dir; end
    if (k == 2) begin ei = cur_oc;  en = cur_dir; end
    if (k == 3) begin ei = cur_oc;  en = cur_oc;  end
    check($sformatf("dp_i_k%0d", k), dp_i, ei);
    check($sformatf("dp_n_k%0d", k), dp_n, en);
  endtask

  task automatic wait_result(input bit trace, output exp_t e);
    int cnt;
    cnt = 0;
    while (1) begin
      if (trace) check_ops(cnt);
      if (out_valid || cnt >= 20) break;
      step();
      cnt++;
    end
    check("result_latency", cnt, 5);
    check("scoreboard_nonempty", sb.size() != 0, 1);
    e.disc = '0;
    e.hit = 1'b0;
    e.is_nan = 1'b0;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("out_hit", out_hit, e.hit);
      if (e.is_nan)
        check("out_disc_nan", (out_disc[62:52] == 11'h7ff) && (out_disc[51:0] != 0), 1);
      else
        check("out_disc", out_disc, e.disc);
    end
  endtask

  task automatic release_result(input exp_t e);
    out_ready = 1'b1;
    step();
    check_idle_outputs("release");
    check("hold_hit", out_hit, e.hit);
    if (!e.is_nan) check("hold_disc", out_disc, e.disc);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    in_valid = 1'b0;
    in_origin = '0;
    in_dir = '0;
    in_center = '0;
    in_rad = '0;
    out_ready = 1'b1;
    cur_dir = '0;
    cur_oc = '0;
    step();
    step();
    check_idle_outputs("reset");
    check("reset_hit", out_hit, 0);
    check("reset_disc", out_disc, 0);
    rst = 1'b0;
    step();

    // Hit case with operand trace
    accept_job(vec(0, 0, 0), vec(0, 0, -1), vec(0, 0, -1), $realtobits(0.5), 1.0, 1'b1, 1'b0);
    check("trace_oc_expected", cur_oc, vec(0, 0, 1));
    wait_result(1'b1, e);
    release_result(e);

    // Miss
    accept_job(vec(0, 0, 0), vec(0, 1, 0), vec(0, 0, -1), $realtobits(0.5), -3.0, 1'b0, 1'b0);
    wait_result(1'b0, e);
    release_result(e);

    // Tangent: d == +0.0 must not hit
    accept_job(vec(0, 0, 0), vec(1, 0, 0), vec(0, 0, -1), $realtobits(1.0), 0.0, 1'b0, 1'b0);
    wait_result(1'b0, e);
    release_result(e);

    // NaN radius propagates to a NaN discriminant, which must not hit
    accept_job(vec(0, 0, 0), vec(0, 0, -1), vec(0, 0, -1), 64'h7ff8_0000_0000_0000, 0.0, 1'b0,
               1'b1);
    wait_result(1'b0, e);
    release_result(e);

    // Backpressure with inputs scrambled after accept
    out_ready = 1'b0;
    accept_job(vec(0, 0, 0), vec(0, 0, -1), vec(0, 0, -1), $realtobits(0.5), 1.0, 1'b1, 1'b0);
    in_origin = vec(7, 8, 9);
    in_dir = vec(-3, 2, 5);
    in_center = vec(1, 1, 1);
    in_rad = $realtobits(42.0);
    wait_result(1'b0, e);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_origin = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step();
      check("bp_out_valid", out_valid, 1);
      check("bp_out_hit", out_hit, 1);
      check("bp_out_disc", out_disc, $realtobits(1.0));
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    release_result(e);

    // Back-to-back second job at the minimum initiation interval
    accept_job(vec(0, 0, 0), vec(0, 1, 0), vec(0, 0, -1), $realtobits(0.5), -3.0, 1'b0, 1'b0);
    wait_result(1'b0, e);
    release_result(e);

    // Reset while in DB discards the job
    accept_job(vec(0, 0, 0), vec(0, 0, -1), vec(0, 0, -1), $realtobits(0.5), 1.0, 1'b1, 1'b0);
    step();
    step();
    check("db_dp_n", dp_n, cur_dir);
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb.pop_back());
    check_idle_outputs("midreset");
    check("midreset_hit", out_hit, 0);
    check("midreset_disc", out_disc, 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (out_valid) seen++;
      end
      check("midreset_no_valid", seen, 0);
    end

    // Reset beats a simultaneous request
    rst = 1'b1;
    in_valid = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_vs_valid_busy", busy, 0);
    step();
    check("rst_vs_valid_still_idle", busy, 0);

    // Fresh job after reset
    accept_job(vec(0, 0, 0), vec(1, 0, 0), vec(0, 0, -1), $realtobits(1.0), 0.0, 1'b0, 1'b0);
    wait_result(1'b0, e);
    release_result(e);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
